// File: rtl/phy_wifi_fifo_pkg.sv
// Shared definitions for the phy_wifi asynchronous FIFO: default sizes,
// output-buffer state encoding and Gray/binary pointer conversion.
package phy_wifi_fifo_pkg;

  localparam int ADDR_FIFO_DEF = 4;
  localparam int DATA_W_DEF    = 8;

  // The encoding equals the buffer occupancy, so the state doubles as occ.
  typedef enum logic [1:0] {
    S_ZERO = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } ob_state_e;

  // Callers zero-extend narrower pointers and cast back; the leading zeros
  // leave the conversion unchanged for any width up to 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer: captures registered RAM data and presents it on a
// valid/ready stream. The head is held stable until it is accepted.
module fifo_out_skid
  import phy_wifi_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  ob_state_e         state_q, state_d;
  logic [DATA_W-1:0] head_q, tail_q;
  logic              pop;

  assign valid_o = (state_q != S_ZERO);
  assign pop     = valid_o & ready_i;
  assign data_o  = head_q;
  assign occ_o   = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_ZERO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ZERO:  if (push_i) state_d = S_ONE;
      S_ONE: begin
        if (push_i && !pop)      state_d = S_TWO;
        else if (!push_i && pop) state_d = S_ZERO;
      end
      S_TWO:   if (pop && !push_i) state_d = S_ONE;
      default: state_d = S_ZERO;
    endcase
  end

  // Word storage carries no reset; the state alone decides what is valid.
  always_ff @(posedge clk_i) begin
    unique case (state_q)
      S_ZERO: if (push_i) head_q <= data_i;
      S_ONE: begin
        if (push_i && pop) head_q <= data_i;
        else if (push_i)   tail_q <= data_i;
      end
      S_TWO: begin
        if (pop) begin
          head_q <= tail_q;
          if (push_i) tail_q <= data_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the phy_wifi async FIFO: owns the read pointer,
// empty/level flags and RAM read strobe, and streams words out via a skid.
module fifo_rd_ctrl
  import phy_wifi_fifo_pkg::*;
#(
  parameter int ADDR_FIFO = ADDR_FIFO_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AE_TH     = 2
) (
  input  logic                 R_CLK,
  input  logic                 R_rst,
  input  logic [ADDR_FIFO:0]   Rq2_wptr,
  output logic [ADDR_FIFO:0]   R_ptr,
  output logic                 R_en,
  output logic [ADDR_FIFO-1:0] R_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 R_empty,
  output logic [ADDR_FIFO:0]   R_level,
  output logic                 R_almost_empty
);

  localparam int PW = ADDR_FIFO + 1;

  logic [PW-1:0] rbin_q, rbin_d, rgray_d, wbin, lvl_d;
  logic [PW-1:0] rptr_q, level_q;
  logic          empty_q, ae_q, inflight_q;
  logic [1:0]    occ;
  logic          pop;
  logic [2:0]    committed, budget;

  assign wbin = PW'(gray2bin(32'(Rq2_wptr)));
  assign pop  = m_valid & m_ready;

  // A read may issue only if its word will find a free buffer slot, counting
  // the slot freed by this cycle's pop; empty_q holds R_en low during reset.
  assign committed = {1'b0, occ} + {2'b00, inflight_q};
  assign budget    = 3'd2 + {2'b00, pop};
  assign R_en      = !empty_q && (committed < budget);

  assign rbin_d  = rbin_q + PW'(R_en);
  assign rgray_d = PW'(bin2gray(32'(rbin_d)));
  assign lvl_d   = wbin - rbin_d;

  always_ff @(posedge R_CLK or posedge R_rst) begin
    if (R_rst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      empty_q    <= 1'b1;
      level_q    <= '0;
      ae_q       <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rgray_d;
      empty_q    <= (rgray_d == Rq2_wptr);
      level_q    <= lvl_d;
      ae_q       <= (lvl_d <= PW'(AE_TH));
      inflight_q <= R_en;
    end
  end

  assign R_ptr          = rptr_q;
  assign R_addr         = rbin_q[ADDR_FIFO-1:0];
  assign R_empty        = empty_q;
  assign R_level        = level_q;
  assign R_almost_empty = ae_q;

  fifo_out_skid #(.DATA_W(DATA_W)) u_skid (
    .clk_i   (R_CLK),
    .rst_i   (R_rst),
    .push_i  (inflight_q),
    .data_i  (mem_rdata),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .occ_o   (occ)
  );

  a_no_overflow: assert property (@(posedge R_CLK) disable iff (R_rst) committed <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a RAM/write-side model feeds words,
// and a scoreboard queue checks stream order and content.
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          R_CLK = 1'b0;
  logic          R_rst = 1'b1;
  logic [PW-1:0] Rq2_wptr = '0;
  logic [PW-1:0] R_ptr, R_level;
  logic          R_en, m_valid, R_empty, R_almost_empty;
  logic          m_ready = 1'b0;
  logic [AW-1:0] R_addr;
  logic [DW-1:0] mem_rdata, m_data;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  logic [PW-1:0] wbin = '0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 R_CLK = ~R_CLK;

  fifo_rd_ctrl #(.ADDR_FIFO(AW), .DATA_W(DW), .AE_TH(2)) dut (
    .R_CLK          (R_CLK),
    .R_rst          (R_rst),
    .Rq2_wptr       (Rq2_wptr),
    .R_ptr          (R_ptr),
    .R_en           (R_en),
    .R_addr         (R_addr),
    .mem_rdata      (mem_rdata),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .R_empty        (R_empty),
    .R_level        (R_level),
    .R_almost_empty (R_almost_empty)
  );

  // Registered-output RAM model
  always @(posedge R_CLK) if (R_en) mem_rdata <= mem[R_addr];

  // Scoreboard: every accepted word must be the oldest outstanding one
  always @(negedge R_CLK) begin
    if (!R_rst && m_valid && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL stream_extra: got %h, no word outstanding", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_data !== mon_exp) $display("FAIL stream_data: got %h, expected %h", m_data, mon_exp);
        else n_pass++;
      end
    end
  end

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wbin[AW-1:0]] = DW'($urandom);
      exp_q.push_back(mem[wbin[AW-1:0]]);
      wbin = wbin + 1'b1;
    end
    Rq2_wptr = to_gray(wbin);
  endtask

  task automatic do_reset();
    R_rst = 1'b1;
    m_ready = 1'b0;
    wbin = '0;
    Rq2_wptr = '0;
    exp_q.delete();
    tick();
    tick();
    R_rst = 1'b0;
  endtask

  task automatic check_queue_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drained: %0d words left, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    R_rst = 1'b1;
    m_ready = 1'b1;
    Rq2_wptr = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {R_empty, R_ptr, R_level, m_valid, R_en, R_almost_empty};
      n_checks++;
      if (obs !== {1'b1, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1})
        $display("FAIL reset_state: {empty,ptr,level,valid,en,ae}=%b, expected %b", obs, {1'b1, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1});
      else n_pass++;
    end
    Rq2_wptr = '0;
    wbin = '0;
    R_rst = 1'b0;
  endtask

  task automatic test_single();
    logic [8:0] o1;
    logic [7:0] o2;
    do_reset();
    m_ready = 1'b1;
    push_words(1);
    tick();
    o1 = {R_empty, R_en, R_addr, m_valid, R_level[1:0]};
    n_checks++;
    if (o1 !== {1'b0, 1'b1, 4'd0, 1'b0, 2'd1}) $display("FAIL single_e1: got %b, expected %b", o1, {1'b0, 1'b1, 4'd0, 1'b0, 2'd1});
    else n_pass++;
    tick();
    o2 = {R_empty, R_en, m_valid, R_ptr};
    n_checks++;
    if (o2 !== {1'b1, 1'b0, 1'b0, 5'b00001} || R_level !== 5'd0)
      $display("FAIL single_e2: {empty,en,valid,ptr}=%b level=%0d, expected 10000001 level=0", o2, R_level);
    else n_pass++;
    tick();
    n_checks++;
    if ({m_valid, R_en} !== 2'b10) $display("FAIL single_e3: {valid,en}=%b, expected 10", {m_valid, R_en});
    else n_pass++;
    tick();
    n_checks++;
    if ({m_valid, R_empty} !== 2'b01) $display("FAIL single_e4: {valid,empty}=%b, expected 01", {m_valid, R_empty});
    else n_pass++;
    check_queue_drained("single");
  endtask

  task automatic test_burst();
    int vc = 0;
    int first = -1;
    int last = -1;
    do_reset();
    m_ready = 1'b1;
    push_words(16);
    n_checks++;
    if (Rq2_wptr !== 5'b11000) $display("FAIL burst_stim: wptr=%b, expected 11000", Rq2_wptr);
    else n_pass++;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) begin
        n_checks++;
        if (R_level !== 5'd16 || R_empty !== 1'b0) $display("FAIL burst_level: level=%0d empty=%b, expected 16 0", R_level, R_empty);
        else n_pass++;
      end
      if (k <= 16) begin
        n_checks++;
        if ({R_en, R_addr} !== {1'b1, AW'(k - 1)}) $display("FAIL burst_read: k=%0d en=%b addr=%0d, expected 1 %0d", k, R_en, R_addr, k - 1);
        else n_pass++;
      end else if (k == 17) begin
        n_checks++;
        if (R_en !== 1'b0) $display("FAIL burst_stop: en=%b, expected 0", R_en);
        else n_pass++;
      end
      if (m_valid) begin
        if (first < 0) first = k;
        last = k;
        vc++;
      end
    end
    n_checks++;
    if (vc != 16 || last - first + 1 != 16 || first != 3)
      $display("FAIL burst_valid: count=%0d first=%0d last=%0d, expected 16 3 18", vc, first, last);
    else n_pass++;
    n_checks++;
    if ({R_ptr, R_level, R_empty} !== {5'b11000, 5'd0, 1'b1})
      $display("FAIL burst_final: ptr=%b level=%0d empty=%b, expected 11000 0 1", R_ptr, R_level, R_empty);
    else n_pass++;
    check_queue_drained("burst");
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int vc = 0;
    int first = -1;
    int last = -1;
    do_reset();
    push_words(4);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (R_en) pulses++;
      if (k >= 4) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp_q[0]) $display("FAIL bp_hold: k=%0d valid=%b data=%h, expected 1 %h", k, m_valid, m_data, exp_q[0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 2 || R_level !== 5'd2) $display("FAIL bp_reads: pulses=%0d level=%0d, expected 2 2", pulses, R_level);
    else n_pass++;
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (m_valid) begin
        if (first < 0) first = k;
        last = k;
        vc++;
      end
      tick();
    end
    n_checks++;
    if (vc != 4 || first != 0 || last != 3) $display("FAIL bp_release: count=%0d first=%0d last=%0d, expected 4 0 3", vc, first, last);
    else n_pass++;
    check_queue_drained("bp");
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wrap_addr [4];
    wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_reset();
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_words(10);
      repeat (20) tick();
    end
    n_checks++;
    if ({R_ptr, R_empty} !== {5'b10001, 1'b1}) $display("FAIL wrap_pre: ptr=%b empty=%b, expected 10001 1", R_ptr, R_empty);
    else n_pass++;
    push_words(4);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({R_en, R_addr} !== {1'b1, wrap_addr[k]}) $display("FAIL wrap_addr: k=%0d en=%b addr=%0d, expected 1 %0d", k, R_en, R_addr, wrap_addr[k]);
      else n_pass++;
    end
    repeat (6) tick();
    n_checks++;
    if ({R_ptr, R_level, R_empty} !== {5'b00011, 5'd0, 1'b1})
      $display("FAIL wrap_final: ptr=%b level=%0d empty=%b, expected 00011 0 1", R_ptr, R_level, R_empty);
    else n_pass++;
    check_queue_drained("wrap");
  endtask

  task automatic test_reset_mid();
    logic [13:0] obs;
    do_reset();
    push_words(4);
    repeat (3) tick();
    n_checks++;
    if ({m_valid, R_empty} !== 2'b10) $display("FAIL rmid_pre: {valid,empty}=%b, expected 10", {m_valid, R_empty});
    else n_pass++;
    R_rst = 1'b1;
    #1;
    obs = {R_empty, R_ptr, R_level, m_valid, R_en, R_almost_empty};
    n_checks++;
    if (obs !== {1'b1, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1}) $display("FAIL rmid_async: got %b, expected %b", obs, {1'b1, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1});
    else n_pass++;
    exp_q.delete();
    wbin = '0;
    Rq2_wptr = '0;
    tick();
    R_rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if ({m_valid, R_en, R_empty} !== 3'b001) $display("FAIL rmid_idle: k=%0d {valid,en,empty}=%b, expected 001", k, {m_valid, R_en, R_empty});
      else n_pass++;
    end
    push_words(1);
    repeat (6) tick();
    check_queue_drained("rmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
